microwave_ctrl_p: RTL and testbench
===================================

Name: microwave_ctrl_p

Overview:
- Parametrised next-generation microwave controller: keypad time entry, power-level selection, 1 Hz countdown in BCD m:ss and magnetron duty cycling in one synchronous block.
- Adds door-pause/resume, a latched DONE state that cannot re-arm the timer, and a timed done-beep.
- Feeds the existing bcd_7segmentos decoder through its BCD outputs.

Parameters:
- TICK_DIV, 50000000, clock cycles per 1 s tick (≥2).
- DUTY_WINDOW, 10, ticks per power window; power level L (1..DUTY_WINDOW) gives magnetron on for the first L ticks of each window.
- BEEP_TICKS, 3, length of done beep in ticks.

Ports:
- clock  in  1  system clock
- clrn  in  1  async active-low reset
- keypad  in  10  one-hot digit keys 0..9, level, asynchronous to clock
- startn  in  1  start/resume button, active-low level
- stopn  in  1  pause (COOK), cancel (PAUSED/ENTRY/POWER_SEL), active-low
- powern  in  1  enter power-select, active-low
- door_closed  in  1  1 = door closed
- mag_on  out  1  magnetron enable
- lamp  out  1  cavity lamp
- beep  out  1  done buzzer
- mins  out  4  BCD minutes
- sec_tens  out  4  BCD tens of seconds
- sec_ones  out  4  BCD seconds
- power_lvl  out  4  current power level, binary

Behaviour:
- Reset (clrn=0, async): state IDLE, digits 0:00, power_lvl=DUTY_WINDOW, mag_on=lamp=beep=0, prescaler/window counters 0.
- All async inputs pass 2-flop synchronisers; buttons act on synchronised falling edge (1-cycle event). Key event = synchronised keypad goes from all-zero to exactly one bit set; multiple bits set is ignored. Input-to-action latency 3 cycles.
- States: IDLE, ENTRY, POWER_SEL, COOK, PAUSED, DONE.
- IDLE: digit key -> ENTRY with that digit loaded into sec_ones, other digits 0. powern -> POWER_SEL.
- ENTRY: digit key shifts left: mins<=sec_tens, sec_tens<=sec_ones, sec_ones<=key; old mins lost. startn with door_closed=1 and time≠0:00 -> COOK. startn with door open or 0:00 is ignored. stopn -> IDLE, time cleared. powern -> POWER_SEL, time kept.
- POWER_SEL: next digit key sets power_lvl (0 means DUTY_WINDOW, 1..9 as-is, clamped to DUTY_WINDOW), then return to ENTRY if time≠0:00, else IDLE. stopn returns without change.
- On COOK entry: prescaler and window counter cleared, so the first tick arrives exactly TICK_DIV cycles later.
- COOK countdown, each tick: sec_ones-1. If sec_ones=0, borrow: sec_ones=9, sec_tens-1. If both are 0, borrow from mins: sec_tens=5, sec_ones=9. Entered values with sec_tens>5 count naturally (0:75 lasts 75 ticks).
- COOK completion: the tick that reaches 0:00 moves to DONE the same cycle; no further decrement.
- COOK: mag_on=1 iff window counter < power_lvl. Window counter increments per tick and wraps at DUTY_WINDOW-1 -> 0.
- COOK exits: door_closed=0 -> PAUSED, with mag_on dropped within 3 cycles of the pin change. stopn -> PAUSED. Keys are ignored.
- PAUSED: time, window and prescaler frozen; mag_on=0. startn with door closed -> COOK, with counters resumed, not cleared. stopn -> IDLE, time cleared.
- DONE: display 0:00, mag_on=0, beep=1 for BEEP_TICKS ticks, then 0. Exits to IDLE (power reset to DUTY_WINDOW) on stopn, on door open, or on any key (that key is not loaded). startn is ignored; the timer never re-arms from DONE.
- lamp=1 in COOK, or whenever door_closed=0.
- Simultaneous events in one cycle, priority: door open > stopn > startn > powern > key.
- Reset mid-COOK: immediate return to reset values; mag_on falls asynchronously.

Test Plan (TICK_DIV=4, DUTY_WINDOW=10, BEEP_TICKS=3):
- Keys 1,3,0, startn, door closed -> display 1:30, COOK. After 90 ticks (360 cycles) display 0:00, DONE. beep high exactly 12 cycles. mag_on continuously 1.
- Keys 7,5, startn -> counts 0:75, 0:74 … 0:00 in 75 ticks. Keys 1,2,3,4 -> display 2:34.
- powern, key 3, keys 2,0, startn -> power_lvl=3. mag_on high 3 ticks, low 7 ticks, repeating. DONE after 20 ticks.
- Cooking 0:10, open door after 4 ticks -> mag_on=0 within 3 cycles, display frozen at 0:06, lamp=1. Close door, startn -> resumes from 0:06. stopn in PAUSED -> IDLE, 0:00.
- In DONE, pulse startn repeatedly -> state stays DONE, display stays 0:00, mag_on stays 0. Key press -> IDLE with display 0:00.
- Assert clrn low mid-COOK at 0:42 -> mag_on=0 without a clock edge; all outputs at reset values. startn with 0:00 in ENTRY, or with door open -> no COOK.

Source files
------------

// File: rtl/microwave_ctrl_p.sv
// Microwave controller: keypad m:ss entry, power level, 1 Hz BCD countdown,
// magnetron duty cycling, door pause/resume and a timed done beep.
module microwave_ctrl_p #(
  parameter int TICK_DIV    = 50000000,
  parameter int DUTY_WINDOW = 10,
  parameter int BEEP_TICKS  = 3
) (
  input  logic       clock,
  input  logic       clrn,
  input  logic [9:0] keypad,
  input  logic       startn,
  input  logic       stopn,
  input  logic       powern,
  input  logic       door_closed,
  output logic       mag_on,
  output logic       lamp,
  output logic       beep,
  output logic [3:0] mins,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] power_lvl
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = $clog2(BEEP_TICKS + 1);
  localparam logic [3:0] DW4 = 4'(DUTY_WINDOW);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ENTRY = 3'd1;
  localparam logic [2:0] S_PSEL  = 3'd2;
  localparam logic [2:0] S_COOK  = 3'd3;
  localparam logic [2:0] S_PAUSE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // Buttons and door idle high so a reset never fabricates an edge or a door-open
  localparam logic [13:0] SYNC_RST = {4'hF, 10'h000};

  logic [13:0] meta_q, sync_q;
  logic [12:0] prev_q;

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      meta_q <= SYNC_RST;
      sync_q <= SYNC_RST;
      prev_q <= SYNC_RST[12:0];
    end else begin
      meta_q <= {door_closed, powern, stopn, startn, keypad};
      sync_q <= meta_q;
      prev_q <= sync_q[12:0];
    end
  end

  logic [9:0] key_s;
  logic       door_s, start_ev, stop_ev, power_ev, key_ev;
  logic [3:0] key_d;

  assign key_s    = sync_q[9:0];
  assign door_s   = sync_q[13];
  assign start_ev = prev_q[10] & ~sync_q[10];
  assign stop_ev  = prev_q[11] & ~sync_q[11];
  assign power_ev = prev_q[12] & ~sync_q[12];
  assign key_ev   = (prev_q[9:0] == 10'd0) && $onehot(key_s);

  always_comb begin
    key_d = 4'd0;
    for (int i = 0; i < 10; i++)
      if (key_s[i]) key_d = 4'(i);
  end

  logic [2:0]    state_q, state_d;
  logic [3:0]    mins_q, mins_d, tens_q, tens_d, ones_q, ones_d;
  logic [3:0]    pwr_q, pwr_d, win_q, win_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] beep_q, beep_d;

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state_q <= S_IDLE;
      mins_q  <= 4'd0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      pwr_q   <= DW4;
      win_q   <= 4'd0;
      presc_q <= '0;
      beep_q  <= '0;
    end else begin
      state_q <= state_d;
      mins_q  <= mins_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      pwr_q   <= pwr_d;
      win_q   <= win_d;
      presc_q <= presc_d;
      beep_q  <= beep_d;
    end
  end

  logic          tick, time_zero, dec_zero;
  logic [PW-1:0] presc_nxt;
  logic [3:0]    win_nxt, pwr_key;
  logic [3:0]    dec_m, dec_t, dec_o;

  assign tick      = (presc_q == PW'(TICK_DIV - 1));
  assign presc_nxt = tick ? '0 : presc_q + 1'b1;
  assign win_nxt   = (win_q == 4'(DUTY_WINDOW - 1)) ? 4'd0 : win_q + 4'd1;
  assign time_zero = ({mins_q, tens_q, ones_q} == 12'd0);
  assign pwr_key   = (key_d == 4'd0 || key_d > DW4) ? DW4 : key_d;

  // BCD borrow chain; tens above 5 simply count down as entered
  always_comb begin
    dec_m = mins_q;
    dec_t = tens_q;
    dec_o = ones_q;
    if (ones_q != 4'd0) begin
      dec_o = ones_q - 4'd1;
    end else if (tens_q != 4'd0) begin
      dec_o = 4'd9;
      dec_t = tens_q - 4'd1;
    end else begin
      dec_o = 4'd9;
      dec_t = 4'd5;
      dec_m = mins_q - 4'd1;
    end
  end
  assign dec_zero = ({dec_m, dec_t, dec_o} == 12'd0);

  always_comb begin
    state_d = state_q;
    mins_d  = mins_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    pwr_d   = pwr_q;
    win_d   = win_q;
    presc_d = presc_q;
    beep_d  = beep_q;
    case (state_q)
      S_IDLE: begin
        if (power_ev) begin
          state_d = S_PSEL;
        end else if (key_ev) begin
          state_d = S_ENTRY;
          mins_d  = 4'd0;
          tens_d  = 4'd0;
          ones_d  = key_d;
        end
      end
      S_ENTRY: begin
        if (stop_ev) begin
          state_d = S_IDLE;
          mins_d  = 4'd0;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
        end else if (start_ev && door_s && !time_zero) begin
          state_d = S_COOK;
          presc_d = '0;
          win_d   = 4'd0;
        end else if (power_ev) begin
          state_d = S_PSEL;
        end else if (key_ev) begin
          mins_d = tens_q;
          tens_d = ones_q;
          ones_d = key_d;
        end
      end
      S_PSEL: begin
        if (stop_ev || key_ev) begin
          state_d = time_zero ? S_IDLE : S_ENTRY;
          if (!stop_ev) pwr_d = pwr_key;
        end
      end
      S_COOK: begin
        if (!door_s || stop_ev) begin
          state_d = S_PAUSE;
        end else begin
          presc_d = presc_nxt;
          if (tick) begin
            win_d  = win_nxt;
            mins_d = dec_m;
            tens_d = dec_t;
            ones_d = dec_o;
            if (dec_zero) begin
              state_d = S_DONE;
              presc_d = '0;
              beep_d  = '0;
            end
          end
        end
      end
      S_PAUSE: begin
        if (stop_ev) begin
          state_d = S_IDLE;
          mins_d  = 4'd0;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
        end else if (start_ev && door_s) begin
          state_d = S_COOK;
        end
      end
      S_DONE: begin
        presc_d = presc_nxt;
        if (tick && beep_q < BW'(BEEP_TICKS)) beep_d = beep_q + 1'b1;
        if (!door_s || stop_ev || key_ev) begin
          state_d = S_IDLE;
          pwr_d   = DW4;
          presc_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Gated by the synchronised door too, so the magnetron drops a cycle before PAUSED
  assign mag_on    = (state_q == S_COOK) && door_s && (win_q < pwr_q);
  assign lamp      = (state_q == S_COOK) || !door_s;
  assign beep      = (state_q == S_DONE) && (beep_q < BW'(BEEP_TICKS));
  assign mins      = mins_q;
  assign sec_tens  = tens_q;
  assign sec_ones  = ones_q;
  assign power_lvl = pwr_q;

endmodule

// File: tb/tb_microwave_ctrl_p.sv
// Directed bench for microwave_ctrl_p with TICK_DIV=4, DUTY_WINDOW=10, BEEP_TICKS=3.
module tb_microwave_ctrl_p;

  logic       clock = 1'b0;
  logic       clrn;
  logic [9:0] keypad;
  logic       startn, stopn, powern, door_closed;
  logic       mag_on, lamp, beep;
  logic [3:0] mins, sec_tens, sec_ones, power_lvl;

  int n_chk  = 0;
  int n_fail = 0;

  microwave_ctrl_p #(.TICK_DIV(4), .DUTY_WINDOW(10), .BEEP_TICKS(3)) dut (
    .clock(clock), .clrn(clrn), .keypad(keypad), .startn(startn), .stopn(stopn),
    .powern(powern), .door_closed(door_closed), .mag_on(mag_on), .lamp(lamp),
    .beep(beep), .mins(mins), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .power_lvl(power_lvl)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] disp();
    return {20'd0, mins, sec_tens, sec_ones};
  endfunction

  // Advance n rising edges, then settle 1 ns past the edge
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press_key(input int d);
    logic [9:0] one;
    one    = 10'd1;
    keypad = one << d;
    cyc(4);
    keypad = 10'd0;
    cyc(4);
  endtask

  task automatic press(input int which);
    case (which)
      0: startn = 1'b0;
      1: stopn  = 1'b0;
      default: powern = 1'b0;
    endcase
    cyc(4);
    startn = 1'b1; stopn = 1'b1; powern = 1'b1;
    cyc(4);
  endtask

  // Drop startn; returns just after the edge where COOK is entered
  task automatic start_sync();
    startn = 1'b0;
    cyc(3);
    startn = 1'b1;
  endtask

  initial begin
    int bad, cnt;
    logic exp_m;
    clrn = 1'b0; keypad = 10'd0; startn = 1'b1; stopn = 1'b1; powern = 1'b1;
    door_closed = 1'b1;
    cyc(3);
    check("rst_mag",   mag_on, 0);
    check("rst_lamp",  lamp, 0);
    check("rst_beep",  beep, 0);
    check("rst_disp",  disp(), 32'h000);
    check("rst_power", power_lvl, 10);
    clrn = 1'b1;
    cyc(3);

    // 1:30 at full power
    press_key(1); press_key(3); press_key(0);
    check("entry_130", disp(), 32'h130);
    start_sync();
    check("cook_mag_on", mag_on, 1);
    check("cook_lamp", lamp, 1);
    bad = 0;
    for (int c = 0; c < 359; c++) begin
      cyc(1);
      if (mag_on !== 1'b1) bad++;
    end
    check("full_pwr_mag_drops", bad, 0);
    check("t130_one_left", disp(), 32'h001);
    cyc(1);
    check("t130_done_disp", disp(), 32'h000);
    check("t130_done_mag", mag_on, 0);
    check("t130_done_beep", beep, 1);
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (beep) cnt++;
      cyc(1);
    end
    check("beep_cycles", cnt, 12);

    // DONE never re-arms
    press(0); press(0); press(0);
    check("done_start_disp", disp(), 32'h000);
    check("done_start_mag", mag_on, 0);
    press_key(5);
    check("done_key_notload", disp(), 32'h000);
    press_key(2);
    check("idle_after_done", disp(), 32'h002);
    press(1);
    check("entry_stop_clear", disp(), 32'h000);

    // 0:75 counts as 75 seconds
    press_key(7); press_key(5);
    check("entry_075", disp(), 32'h075);
    start_sync();
    cyc(4);
    check("t075_first_tick", disp(), 32'h074);
    cyc(36);
    check("t075_10_ticks", disp(), 32'h065);
    cyc(259);
    check("t075_one_left", disp(), 32'h001);
    cyc(1);
    check("t075_done", disp(), 32'h000);
    check("t075_done_beep", beep, 1);
    press(1);
    press_key(1); press_key(2); press_key(3); press_key(4);
    check("entry_shift_234", disp(), 32'h234);
    keypad = 10'b0000001100;
    cyc(6);
    keypad = 10'd0;
    cyc(4);
    check("multikey_ignored", disp(), 32'h234);
    press(1);
    check("stop_clear_234", disp(), 32'h000);

    // power level 3 over a 0:20 cook
    press(2); press_key(3);
    check("power_set_3", power_lvl, 3);
    check("power_idle_disp", disp(), 32'h000);
    press_key(2); press_key(0);
    check("entry_020", disp(), 32'h020);
    start_sync();
    bad = 0;
    for (int c = 0; c < 80; c++) begin
      exp_m = (((c / 4) % 10) < 3);
      if (mag_on !== exp_m) bad++;
      cyc(1);
    end
    check("duty_3of10_pattern", bad, 0);
    check("p3_done_disp", disp(), 32'h000);
    check("p3_done_beep", beep, 1);
    press(1);
    check("done_power_reset", power_lvl, 10);

    // door pause and resume with frozen prescaler
    press_key(1); press_key(0);
    start_sync();
    cyc(16);
    check("door_pre_open", disp(), 32'h006);
    door_closed = 1'b0;
    cyc(3);
    check("door_open_mag", mag_on, 0);
    check("door_open_lamp", lamp, 1);
    cyc(10);
    check("door_frozen", disp(), 32'h006);
    door_closed = 1'b1;
    cyc(5);
    start_sync();
    check("resume_mag", mag_on, 1);
    cyc(1);
    check("resume_no_tick_yet", disp(), 32'h006);
    cyc(1);
    check("resume_counters_kept", disp(), 32'h005);
    press(1);
    check("stop_pause_mag", mag_on, 0);
    check("stop_pause_lamp", lamp, 0);
    press(1);
    check("pause_stop_idle", disp(), 32'h000);

    // async reset mid-cook at 0:42
    press(2); press_key(5);
    check("power_set_5", power_lvl, 5);
    press_key(4); press_key(2);
    start_sync();
    cyc(2);
    check("pre_reset_mag", mag_on, 1);
    #2 clrn = 1'b0;
    #1;
    check("async_rst_mag", mag_on, 0);
    check("async_rst_disp", disp(), 32'h000);
    check("async_rst_power", power_lvl, 10);
    check("async_rst_lamp", lamp, 0);
    cyc(2);
    clrn = 1'b1;
    cyc(3);

    // start refused at 0:00 and with door open
    press_key(0);
    press(0);
    cyc(20);
    check("zero_start_mag", mag_on, 0);
    check("zero_start_lamp", lamp, 0);
    press_key(5);
    check("entry_005", disp(), 32'h005);
    door_closed = 1'b0;
    cyc(4);
    press(0);
    cyc(20);
    check("open_start_mag", mag_on, 0);
    check("open_start_disp", disp(), 32'h005);
    check("open_lamp", lamp, 1);
    door_closed = 1'b1;
    cyc(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
